// File: rtl/cpu_seq_ctrl_if.sv
// Sequencer-facing bus: imem fetch handshake, decoder/execute status and the
// register-file write port. The sequencer takes the master side.
interface cpu_seq_ctrl_if #(
  parameter int XLEN = 32
);
  logic            w_imem_req;
  logic [XLEN-1:0] w_imem_addr;
  logic            w_imem_valid;
  logic [31:0]     w_imem_data;

  logic            w_dec_wb;
  logic [4:0]      w_dec_rd;
  logic            w_dec_jump;
  logic [XLEN-1:0] w_dec_target;
  logic            w_dec_illegal;
  logic            w_ex_done;

  logic            w_rf_we;
  logic [4:0]      w_rf_waddr;

  modport master (
    output w_imem_req, w_imem_addr, w_rf_we, w_rf_waddr,
    input  w_imem_valid, w_imem_data, w_dec_wb, w_dec_rd, w_dec_jump,
           w_dec_target, w_dec_illegal, w_ex_done
  );

  modport slave (
    input  w_imem_req, w_imem_addr, w_rf_we, w_rf_waddr,
    output w_imem_valid, w_imem_data, w_dec_wb, w_dec_rd, w_dec_jump,
           w_dec_target, w_dec_illegal, w_ex_done
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle instruction sequencer: owns PC and IR, walks FETCH/DECODE/EXEC/WB,
// and latches the first halt cause (x30 write, illegal opcode, fetch timeout).
//
// state  | meaning
// IDLE   | waiting for w_run at an instruction boundary
// FETCH  | imem request up, waiting for w_imem_valid (bounded by timeout)
// DECODE | one cycle for the external decoder to flag illegal
// EXEC   | waiting for w_ex_done
// WB     | rf write strobe, PC update, retire
// HALT   | terminal until reset
module cpu_seq_ctrl #(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] RESET_PC      = '0,
  parameter int              FETCH_TIMEOUT = 15
) (
  input  logic             w_clk,
  input  logic             w_rst_n,
  input  logic             w_run,
  cpu_seq_ctrl_if.master   bus,
  output logic [31:0]      r_ir,
  output logic [XLEN-1:0]  r_pc,
  output logic [2:0]       r_state,
  output logic             r_halted,
  output logic [1:0]       r_halt_cause,
  output logic [31:0]      r_retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] CAUSE_X30     = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;
  localparam logic [7:0] TMO_LIM       = 8'(FETCH_TIMEOUT);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [31:0]     retired_q, retired_d;
  logic            halted_q, halted_d;
  logic [1:0]      cause_q, cause_d;
  logic [7:0]      tmo_q, tmo_d;
  logic [7:0]      tmo_inc;
  logic            imem_req;
  logic            rf_we;

  assign tmo_inc = tmo_q + 8'd1;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      cause_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      cause_q   <= cause_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    halted_d  = halted_q;
    cause_d   = cause_q;
    tmo_d     = tmo_q;
    imem_req  = 1'b0;
    rf_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.w_imem_valid) begin
          ir_d    = bus.w_imem_data;
          tmo_d   = '0;
          state_d = S_DECODE;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_LIM) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            cause_d  = CAUSE_TIMEOUT;
          end
        end
      end
      S_DECODE: begin
        if (bus.w_dec_illegal) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          cause_d  = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (bus.w_ex_done) state_d = S_WB;
      end
      S_WB: begin
        rf_we     = bus.w_dec_wb && (bus.w_dec_rd != 5'd0);
        pc_d      = bus.w_dec_jump ? {bus.w_dec_target[XLEN-1:2], 2'b00}
                                   : pc_q + XLEN'(4);
        retired_d = retired_q + 32'd1;
        // x30 write still commits and retires before the halt takes over
        if (bus.w_dec_wb && (bus.w_dec_rd == 5'd30)) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          cause_d  = CAUSE_X30;
        end else begin
          state_d = w_run ? S_FETCH : S_IDLE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.w_imem_req  = imem_req;
  assign bus.w_imem_addr = pc_q;
  assign bus.w_rf_we     = rf_we;
  assign bus.w_rf_waddr  = bus.w_dec_rd;

  assign r_ir         = ir_q;
  assign r_pc         = pc_q;
  assign r_state      = state_q;
  assign r_halted     = halted_q;
  assign r_halt_cause = cause_q;
  assign r_retired    = retired_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Randomized bench for cpu_seq_ctrl: instructions are scheduled at transaction
// level and checked against an architectural model of PC, retire count and halt.
module tb_cpu_seq_ctrl;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          TMO      = 15;

  logic        w_clk   = 1'b0;
  logic        w_rst_n = 1'b0;
  logic        w_run   = 1'b0;
  logic [31:0] r_ir, r_pc, r_retired;
  logic [2:0]  r_state;
  logic        r_halted;
  logic [1:0]  r_halt_cause;

  cpu_seq_ctrl_if #(.XLEN(XLEN)) bus ();

  cpu_seq_ctrl #(.XLEN(XLEN), .RESET_PC(RESET_PC), .FETCH_TIMEOUT(TMO)) dut (
    .w_clk        (w_clk),
    .w_rst_n      (w_rst_n),
    .w_run        (w_run),
    .bus          (bus),
    .r_ir         (r_ir),
    .r_pc         (r_pc),
    .r_state      (r_state),
    .r_halted     (r_halted),
    .r_halt_cause (r_halt_cause),
    .r_retired    (r_retired)
  );

  always #5 w_clk = ~w_clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_retired, m_ir;
  logic [1:0]  m_cause;
  bit          m_halted;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    @(negedge w_clk);
  endtask

  task automatic quiet_inputs();
    bus.w_imem_valid  = 1'b0;
    bus.w_imem_data   = 32'h0;
    bus.w_dec_wb      = 1'b0;
    bus.w_dec_rd      = 5'd0;
    bus.w_dec_jump    = 1'b0;
    bus.w_dec_target  = 32'h0;
    bus.w_dec_illegal = 1'b0;
    bus.w_ex_done     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"},   32'(r_state), 32'd0);
    check_eq({tag, "_pc"},      r_pc, RESET_PC);
    check_eq({tag, "_ir"},      r_ir, 32'h0);
    check_eq({tag, "_retired"}, r_retired, 32'h0);
    check_eq({tag, "_halted"},  32'(r_halted), 32'd0);
    check_eq({tag, "_cause"},   32'(r_halt_cause), 32'd0);
    check_eq({tag, "_req"},     32'(bus.w_imem_req), 32'd0);
    check_eq({tag, "_we"},      32'(bus.w_rf_we), 32'd0);
  endtask

  task automatic do_reset();
    quiet_inputs();
    w_run   = 1'b0;
    w_rst_n = 1'b0;
    #1;
    tick();
    check_reset_outputs("reset");
    w_rst_n   = 1'b1;
    m_pc      = RESET_PC;
    m_retired = 32'h0;
    m_ir      = 32'h0;
    m_cause   = 2'd0;
    m_halted  = 1'b0;
  endtask

  task automatic start_run();
    check_eq("idle_state", 32'(r_state), 32'd0);
    w_run = 1'b1;
    tick();
    check_eq("enter_fetch", 32'(r_state), 32'd1);
  endtask

  task automatic check_halt(input string tag);
    check_eq({tag, "_state"},   32'(r_state), 32'd5);
    check_eq({tag, "_halted"},  32'(r_halted), 32'd1);
    check_eq({tag, "_cause"},   32'(r_halt_cause), 32'(m_cause));
    check_eq({tag, "_req"},     32'(bus.w_imem_req), 32'd0);
    check_eq({tag, "_we"},      32'(bus.w_rf_we), 32'd0);
    check_eq({tag, "_pc"},      r_pc, m_pc);
    check_eq({tag, "_retired"}, r_retired, m_retired);
  endtask

  // One instruction starting in FETCH: df empty fetch cycles, de EXEC stall cycles
  task automatic run_instr(input int df, input int de, input bit wb, input logic [4:0] rd,
                           input bit jump, input logic [31:0] tgt, input bit illegal,
                           input bit run_after, input logic [31:0] data);
    int nmiss;
    bit wr;
    nmiss = (df > TMO) ? TMO : df;
    for (int i = 0; i < nmiss; i++) begin
      bus.w_imem_valid = 1'b0;
      bus.w_imem_data  = $urandom;
      check_eq("fetch_req", 32'(bus.w_imem_req), 32'd1);
      check_eq("fetch_addr", bus.w_imem_addr, m_pc);
      check_eq("fetch_we", 32'(bus.w_rf_we), 32'd0);
      tick();
    end
    if (df >= TMO) begin
      m_halted = 1'b1;
      m_cause  = 2'd3;
      check_halt("timeout");
      return;
    end
    bus.w_imem_valid = 1'b1;
    bus.w_imem_data  = data;
    check_eq("fetch_req", 32'(bus.w_imem_req), 32'd1);
    check_eq("fetch_addr", bus.w_imem_addr, m_pc);
    tick();
    bus.w_imem_valid = 1'b1;
    bus.w_imem_data  = ~data;
    m_ir = data;
    check_eq("decode_state", 32'(r_state), 32'd2);
    check_eq("decode_ir", r_ir, m_ir);
    check_eq("decode_req", 32'(bus.w_imem_req), 32'd0);
    bus.w_dec_wb      = wb;
    bus.w_dec_rd      = rd;
    bus.w_dec_jump    = jump;
    bus.w_dec_target  = tgt;
    bus.w_dec_illegal = illegal;
    tick();
    bus.w_imem_valid  = 1'b0;
    bus.w_dec_illegal = 1'b0;
    if (illegal) begin
      m_halted = 1'b1;
      m_cause  = 2'd2;
      check_halt("illegal");
      return;
    end
    for (int j = 0; j <= de; j++) begin
      bus.w_ex_done = (j == de);
      w_run = 1'($urandom);
      check_eq("exec_state", 32'(r_state), 32'd3);
      check_eq("exec_we", 32'(bus.w_rf_we), 32'd0);
      tick();
    end
    bus.w_ex_done = 1'b0;
    wr = wb && (rd != 5'd0);
    w_run = run_after;
    check_eq("wb_state", 32'(r_state), 32'd4);
    check_eq("wb_we", 32'(bus.w_rf_we), 32'(wr));
    if (wr) check_eq("wb_waddr", 32'(bus.w_rf_waddr), 32'(rd));
    tick();
    quiet_inputs();
    m_pc      = jump ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
    m_retired = m_retired + 32'd1;
    check_eq("post_pc", r_pc, m_pc);
    check_eq("post_retired", r_retired, m_retired);
    check_eq("post_we", 32'(bus.w_rf_we), 32'd0);
    if (wb && rd == 5'd30) begin
      m_halted = 1'b1;
      m_cause  = 2'd1;
      check_halt("x30");
      return;
    end
    check_eq("post_state", 32'(r_state), run_after ? 32'd1 : 32'd0);
    if (!run_after) begin
      w_run = 1'b1;
      tick();
      check_eq("resume_state", 32'(r_state), 32'd1);
    end
  endtask

  task automatic check_frozen(input int n);
    for (int i = 0; i < n; i++) begin
      bus.w_imem_valid = 1'b1;
      bus.w_imem_data  = $urandom;
      bus.w_ex_done    = 1'b1;
      bus.w_dec_wb     = 1'b1;
      bus.w_dec_rd     = 5'd7;
      w_run            = 1'b1;
      tick();
      check_halt("frozen");
      check_eq("frozen_ir", r_ir, m_ir);
    end
    quiet_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    quiet_inputs();
    @(negedge w_clk);
    do_reset();

    start_run();
    for (int k = 0; k < 3; k++) run_instr(0, 0, 1'b1, 5'd5, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00500093 + k);
    check_eq("three_pc", r_pc, 32'd12);
    check_eq("three_retired", r_retired, 32'd3);
    run_instr(0, 0, 1'b0, 5'd9, 1'b1, 32'h103, 1'b0, 1'b1, 32'h1234);
    check_eq("jump_pc", r_pc, 32'h100);
    run_instr(0, 0, 1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h5678);
    run_instr(13, 0, 1'b1, 5'd3, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1111);
    run_instr(14, 0, 1'b1, 5'd4, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2222);
    run_instr(0, 5, 1'b1, 5'd6, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3333);
    run_instr(0, 0, 1'b1, 5'd30, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4444);
    check_frozen(3);

    do_reset();
    start_run();
    run_instr(1, 1, 1'b1, 5'd2, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAA);
    run_instr(0, 0, 1'b1, 5'd2, 1'b0, 32'h0, 1'b1, 1'b1, 32'hBBBB);
    check_eq("illegal_pc", r_pc, 32'd4);
    check_frozen(2);

    do_reset();
    start_run();
    run_instr(15, 0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    check_frozen(2);

    do_reset();
    start_run();
    run_instr(0, 0, 1'b0, 5'd0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'hC0DE);
    check_eq("wrap_pre", r_pc, 32'hFFFF_FFFC);
    run_instr(0, 0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC0DF);
    check_eq("wrap_post", r_pc, 32'h0);

    // async reset landing in EXEC, between clock edges
    do_reset();
    start_run();
    run_instr(0, 0, 1'b1, 5'd8, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFACE);
    bus.w_imem_valid = 1'b1;
    bus.w_imem_data  = 32'hBEEF;
    tick();
    quiet_inputs();
    tick();
    check_eq("pre_areset_state", 32'(r_state), 32'd3);
    #2;
    w_rst_n = 1'b0;
    #1;
    check_reset_outputs("areset");
    @(negedge w_clk);
    w_rst_n   = 1'b1;
    w_run     = 1'b0;
    m_pc      = RESET_PC;
    m_retired = 32'h0;
    m_ir      = 32'h0;
    m_cause   = 2'd0;
    m_halted  = 1'b0;
    start_run();
    check_eq("restart_addr", bus.w_imem_addr, RESET_PC);
    run_instr(0, 0, 1'b1, 5'd1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0101);

    for (int s = 0; s < 8; s++) begin
      do_reset();
      start_run();
      for (int k = 0; k < 25 && !m_halted; k++) begin
        int          df, de;
        bit          wb, jump, illegal, run_after;
        logic [4:0]  rd;
        logic [31:0] tgt, data;
        df        = ($urandom_range(0, 29) == 0) ? TMO : int'($urandom_range(0, 3));
        de        = int'($urandom_range(0, 3));
        wb        = 1'($urandom);
        rd        = 5'($urandom_range(0, 31));
        jump      = ($urandom_range(0, 3) == 0);
        tgt       = $urandom;
        illegal   = ($urandom_range(0, 24) == 0);
        run_after = ($urandom_range(0, 3) != 0);
        data      = $urandom;
        run_instr(df, de, wb, rd, jump, tgt, illegal, run_after, data);
      end
      if (m_halted) check_frozen(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
Multi-cycle sequencer for the single-issue core. It owns the PC and the instruction register. It walks each instruction through FETCH, DECODE, EXEC and WB, drives the instruction-memory request/valid handshake, and issues the one-cycle register-file write strobe. It detects halt conditions: a write to x30, an illegal instruction, or a fetch timeout. It sits between imem, the external decoder/ALU and m_RF, replacing the free-running every-other-cycle PC toggle.

Parameters:
XLEN, 32, PC/address width
RESET_PC, 0, PC value loaded on reset
FETCH_TIMEOUT, 15, max consecutive FETCH cycles without w_imem_valid before timeout halt (1..255)

Ports:
w_clk  input  1  clock, rising edge
w_rst_n  input  1  asynchronous active-low reset
w_run  input  1  start/continue enable, checked only at instruction boundaries
w_imem_req  output  1  fetch request
w_imem_addr  output  XLEN  fetch address, always equal to r_pc
w_imem_valid  input  1  fetch data valid this cycle
w_imem_data  input  32  fetched instruction
r_ir  output  32  instruction register, feeds the external decoder
w_dec_wb  input  1  current instruction writes rd
w_dec_rd  input  5  destination register
w_dec_jump  input  1  redirect PC to w_dec_target
w_dec_target  input  XLEN  jump/branch target
w_dec_illegal  input  1  undecodable instruction
w_ex_done  input  1  execute unit finished
w_rf_we  output  1  register-file write enable
w_rf_waddr  output  5  register-file write address
r_pc  output  XLEN  program counter
r_state  output  3  FSM state (IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5)
r_halted  output  1  core halted
r_halt_cause  output  2  0 none, 1 x30 write, 2 illegal, 3 fetch timeout
r_retired  output  32  retired-instruction count

Behaviour:
- Reset (async, w_rst_n low) takes effect immediately, mid-instruction included:
  - r_state=IDLE, r_pc=RESET_PC, r_ir=0, r_retired=0, r_halted=0, r_halt_cause=0, timeout counter=0.
  - w_imem_req=0, w_rf_we=0 combinationally.
- IDLE: if w_run=1, go to FETCH next cycle; otherwise stay.
- FETCH:
  - w_imem_req=1 every FETCH cycle.
  - On a cycle with w_imem_valid=1: r_ir<=w_imem_data, clear the timeout counter, go to DECODE.
  - Otherwise increment the timeout counter. When it reaches FETCH_TIMEOUT, go to HALT with cause 3.
  - Data with w_imem_valid=1 outside FETCH is ignored.
- DECODE (1 cycle): if w_dec_illegal=1, go to HALT with cause 2; r_pc is unchanged and nothing retires. Otherwise go to EXEC.
- EXEC: stay until w_ex_done=1, then go to WB. A w_ex_done already high on the first EXEC cycle gives a 1-cycle EXEC.
- WB (1 cycle):
  - w_rf_we = w_dec_wb and (w_dec_rd != 0); w_rf_waddr = w_dec_rd.
  - r_pc <= w_dec_jump ? {w_dec_target[XLEN-1:2],2'b00} : r_pc+4, mod 2^XLEN (0xFFFFFFFC+4 wraps to 0).
  - r_retired increments and wraps.
  - If w_dec_wb=1 and w_dec_rd=30: the write and retire still occur, then go to HALT with cause 1.
  - Else go to FETCH if w_run=1, otherwise IDLE.
- Decoder inputs must be stable from DECODE through WB; they are sampled only in DECODE (illegal) and WB (all others).
- w_run=0 mid-instruction does not abort; the current instruction completes.
- HALT: terminal until reset. r_halted=1, w_imem_req=0, w_rf_we=0, r_pc/r_ir/r_retired frozen. The first halt cause is latched.
- Minimum latency: 4 cycles per instruction (FETCH, DECODE, EXEC, WB) with same-cycle imem valid and w_ex_done tied high.
- w_rf_we is never asserted outside WB.

Test Plan:
- Sequence: reset, w_run=1, imem valid same cycle, w_ex_done=1, 3 non-jump instructions writing x5. Required: w_rf_we pulses at cycles 4, 8, 12 after leaving IDLE; r_pc steps 0→4→8→12; r_retired=3.
- Jump: w_dec_jump=1, w_dec_target=0x103 in WB. Required: r_pc=0x100 next cycle; no rf write when w_dec_wb=0.
- x30 halt: instruction with w_dec_wb=1, rd=30. Required: one w_rf_we pulse with waddr=30, r_retired+1, then r_state=5, r_halt_cause=1, w_imem_req stays 0.
- Illegal and rd=0: w_dec_illegal=1 in DECODE gives HALT with cause 2 and r_pc unchanged. A separate run with rd=0 and w_dec_wb=1 gives w_rf_we=0 but still retires.
- Stalls: w_imem_valid held low 15 cycles gives HALT with cause 3. Valid arriving on cycle 14 proceeds normally. w_ex_done delayed 5 cycles keeps r_state=3 for 6 cycles.
- Async reset in EXEC, asserted between clock edges: outputs return to reset values without a clock edge; after release with w_run=1 the fetch restarts from RESET_PC.
